// File: rtl/mastermind_pkg.sv
// Shared definitions for the mastermind game blocks: timer state encoding
// and the default tick divider length (one second at 50 MHz).
package mastermind_pkg;

    localparam int DIV_COUNT_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int div_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : mastermind_pkg

// File: rtl/guess_timer_ctrl_if.sv
// Command and status bundle of the guess timer: the game logic (master)
// issues commands, the timer (slave) reports the countdown.
interface guess_timer_ctrl_if #(
    parameter int TIME_W = 6
) ();

    logic              start;
    logic              stop;
    logic              pause;
    logic              resume;
    logic [TIME_W-1:0] load_secs;
    logic [TIME_W-1:0] time_left;
    logic              tick;
    logic              expired;
    logic              running;
    logic              timeout;

    modport master (
        output start, stop, pause, resume, load_secs,
        input  time_left, tick, expired, running, timeout
    );

    modport slave (
        input  start, stop, pause, resume, load_secs,
        output time_left, tick, expired, running, timeout
    );

endinterface : guess_timer_ctrl_if

// File: rtl/tick_divider.sv
// Free-running cycle divider: counts 0..DIV_COUNT-1 while enabled, holds
// otherwise, and flags the last count so the owner can act on the wrap edge.
module tick_divider
    import mastermind_pkg::*;
#(
    parameter int DIV_COUNT = DIV_COUNT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick_o
);

    localparam int             Q_W    = div_width(DIV_COUNT);
    localparam logic [Q_W-1:0] Q_LAST = Q_W'(DIV_COUNT - 1);

    logic [Q_W-1:0] q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= (q == Q_LAST) ? '0 : q + 1'b1;
        end
    end

    // Combinational on purpose: the controller must see the wrap on the same edge.
    assign tick_o = enable && (q == Q_LAST);

endmodule : tick_divider

// File: rtl/guess_timer_ctrl.sv
// Countdown timer for a guess round: loads a number of seconds, decrements
// once per divider wrap, and supports pause/resume, abort and restart.
module guess_timer_ctrl
    import mastermind_pkg::*;
#(
    parameter int DIV_COUNT = DIV_COUNT_DEFAULT,
    parameter int TIME_W    = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    guess_timer_ctrl_if.slave bus
);

    timer_state_e      state;
    timer_state_e      state_next;
    logic [TIME_W-1:0] time_left_q;
    logic [TIME_W-1:0] time_left_next;
    logic              tick_q;
    logic              tick_next;
    logic              expired_q;
    logic              expired_next;
    logic              running_q;
    logic              timeout_q;

    logic start_ok;
    logic div_enable;
    logic div_clear;
    logic div_tick;

    // A start with zero seconds is not a valid command and is dropped entirely.
    assign start_ok   = bus.start && (bus.load_secs != '0);
    assign div_enable = (state == ST_RUN);
    assign div_clear  = bus.stop || start_ok ||
                        (state == ST_IDLE) || (state == ST_EXPIRED);

    tick_divider #(
        .DIV_COUNT (DIV_COUNT)
    ) u_tick_divider (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (div_enable),
        .clear   (div_clear),
        .tick_o  (div_tick)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the branches below can leave it unassigned and infer a latch.
        state_next     = state;
        time_left_next = time_left_q;
        tick_next      = 1'b0;
        expired_next   = 1'b0;

        if (bus.stop) begin
            state_next     = ST_IDLE;
            time_left_next = '0;
        end else if (start_ok) begin
            state_next     = ST_RUN;
            time_left_next = bus.load_secs;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (bus.pause) begin
                        state_next = ST_PAUSE;
                    end
                    // A tick due on the pause edge still counts; expiry overrides pause.
                    if (div_tick && (time_left_q != '0)) begin
                        tick_next      = 1'b1;
                        time_left_next = time_left_q - 1'b1;
                        if (time_left_q == TIME_W'(1)) begin
                            expired_next = 1'b1;
                            state_next   = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.resume) begin
                        state_next = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    time_left_next = '0;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            time_left_q <= '0;
            tick_q      <= 1'b0;
            expired_q   <= 1'b0;
            running_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_next;
            time_left_q <= time_left_next;
            tick_q      <= tick_next;
            expired_q   <= expired_next;
            running_q   <= (state_next == ST_RUN);
            timeout_q   <= (state_next == ST_EXPIRED);
        end
    end

    assign bus.time_left = time_left_q;
    assign bus.tick      = tick_q;
    assign bus.expired   = expired_q;
    assign bus.running   = running_q;
    assign bus.timeout   = timeout_q;

endmodule : guess_timer_ctrl
